inst_buffer: RTL and testbench

//  Dual-issue instruction fetch queue between fetch (pc_reg + icache) and decode.
//  - Accepts up to two {pc, inst} pairs per cycle.
//  - Presents up to two oldest entries to decode in first-word-fall-through order.
//  - Backpressures fetch via pause_o.
//  - Drops all contents on a branch redirect (flush_i).

---
 rtl/cpu_defs_pkg.sv | 21 ++
 rtl/inst_buffer.sv | 109 ++++++++++
 tb/tb_inst_buffer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
//------------------------------------------------------------------------------
// Module  : cpu_defs_pkg
// Brief   : Shared CPU front-end types and sizing constants.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_defs_pkg;

   localparam int INST_BUF_DEPTH = 8;
   localparam int ADDR_W         = 32;
   localparam int INST_W         = 32;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/inst_buffer.sv
//------------------------------------------------------------------------------
// Module  : inst_buffer
// Brief   : Dual-issue FWFT instruction queue between fetch and decode.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module inst_buffer
   import cpu_defs_pkg::*;
#(
   parameter int DEPTH  = INST_BUF_DEPTH,
   parameter int ADDR_W = cpu_defs_pkg::ADDR_W,
   parameter int INST_W = cpu_defs_pkg::INST_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush_i,
   input  logic                       enq_valid_1_i,
   input  logic                       enq_valid_2_i,
   input  logic [ADDR_W-1:0]          enq_pc_1_i,
   input  logic [INST_W-1:0]          enq_inst_1_i,
   input  logic [ADDR_W-1:0]          enq_pc_2_i,
   input  logic [INST_W-1:0]          enq_inst_2_i,
   input  logic [1:0]                 deq_pop_i,
   output logic                       deq_valid_1_o,
   output logic [ADDR_W-1:0]          deq_pc_1_o,
   output logic [INST_W-1:0]          deq_inst_1_o,
   output logic                       deq_valid_2_o,
   output logic [ADDR_W-1:0]          deq_pc_2_o,
   output logic [INST_W-1:0]          deq_inst_2_o,
   output logic                       pause_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;

   logic [ADDR_W-1:0]  r_pc_mem   [DEPTH];
   logic [INST_W-1:0]  r_inst_mem [DEPTH];

   logic [c_PTR_W-1:0] r_head;
   logic [c_PTR_W-1:0] r_tail;
   logic [c_CNT_W-1:0] r_count;

   logic [c_PTR_W-1:0] w_head_p1;
   logic [c_PTR_W-1:0] w_tail_p1;
   logic               w_enq_ok;
   logic               w_wr_1;
   logic               w_wr_2;
   logic [1:0]         w_n_enq;
   logic [1:0]         w_pop_req;
   logic [1:0]         w_n_pop;

   assign w_head_p1 = r_head + c_PTR_W'(1);
   assign w_tail_p1 = r_tail + c_PTR_W'(1);

   // pause_o depends on registered count only, so fetch never sees a
   // combinational path through decode's pop.
   assign pause_o  = (r_count > c_CNT_W'(DEPTH - 2));
   assign w_enq_ok = !pause_o && !flush_i;
   assign w_wr_1   = w_enq_ok && enq_valid_1_i;
   assign w_wr_2   = w_wr_1 && enq_valid_2_i;
   assign w_n_enq  = {1'b0, w_wr_1} + {1'b0, w_wr_2};

   assign w_pop_req = (deq_pop_i == 2'd3) ? 2'd2 : deq_pop_i;

   always_comb begin
      w_n_pop = w_pop_req;
      if (r_count < c_CNT_W'(w_pop_req)) begin
         w_n_pop = r_count[1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (w_wr_1) begin
            r_pc_mem[r_tail]   <= enq_pc_1_i;
            r_inst_mem[r_tail] <= enq_inst_1_i;
         end
         if (w_wr_2) begin
            r_pc_mem[w_tail_p1]   <= enq_pc_2_i;
            r_inst_mem[w_tail_p1] <= enq_inst_2_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + c_PTR_W'(w_n_pop);
         r_tail  <= r_tail + c_PTR_W'(w_n_enq);
         r_count <= r_count + c_CNT_W'(w_n_enq) - c_CNT_W'(w_n_pop);
      end
   end

   assign deq_valid_1_o = (r_count >= c_CNT_W'(1));
   assign deq_valid_2_o = (r_count >= c_CNT_W'(2));
   assign deq_pc_1_o    = deq_valid_1_o ? r_pc_mem[r_head]      : '0;
   assign deq_inst_1_o  = deq_valid_1_o ? r_inst_mem[r_head]    : '0;
   assign deq_pc_2_o    = deq_valid_2_o ? r_pc_mem[w_head_p1]   : '0;
   assign deq_inst_2_o  = deq_valid_2_o ? r_inst_mem[w_head_p1] : '0;
   assign count_o       = r_count;

endmodule

`default_nettype wire

// File: tb/tb_inst_buffer.sv
//------------------------------------------------------------------------------
// Module  : tb_inst_buffer
// Brief   : Directed self-checking bench for inst_buffer (DEPTH = 8).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_inst_buffer;

   logic        clk;
   logic        rst;
   logic        flush_i;
   logic        enq_valid_1_i;
   logic        enq_valid_2_i;
   logic [31:0] enq_pc_1_i;
   logic [31:0] enq_inst_1_i;
   logic [31:0] enq_pc_2_i;
   logic [31:0] enq_inst_2_i;
   logic [1:0]  deq_pop_i;
   logic        deq_valid_1_o;
   logic [31:0] deq_pc_1_o;
   logic [31:0] deq_inst_1_o;
   logic        deq_valid_2_o;
   logic [31:0] deq_pc_2_o;
   logic [31:0] deq_inst_2_o;
   logic        pause_o;
   logic [3:0]  count_o;

   int total;
   int bad;

   inst_buffer #(.DEPTH(8), .ADDR_W(32), .INST_W(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .flush_i       (flush_i),
      .enq_valid_1_i (enq_valid_1_i),
      .enq_valid_2_i (enq_valid_2_i),
      .enq_pc_1_i    (enq_pc_1_i),
      .enq_inst_1_i  (enq_inst_1_i),
      .enq_pc_2_i    (enq_pc_2_i),
      .enq_inst_2_i  (enq_inst_2_i),
      .deq_pop_i     (deq_pop_i),
      .deq_valid_1_o (deq_valid_1_o),
      .deq_pc_1_o    (deq_pc_1_o),
      .deq_inst_1_o  (deq_inst_1_o),
      .deq_valid_2_o (deq_valid_2_o),
      .deq_pc_2_o    (deq_pc_2_o),
      .deq_inst_2_o  (deq_inst_2_o),
      .pause_o       (pause_o),
      .count_o       (count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mk_inst(input logic [31:0] pc);
      return pc ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v1, input logic v2, input logic [31:0] pc1,
                        input logic [31:0] pc2, input logic [1:0] pop, input logic fl);
      enq_valid_1_i = v1;
      enq_valid_2_i = v2;
      enq_pc_1_i    = pc1;
      enq_inst_1_i  = mk_inst(pc1);
      enq_pc_2_i    = pc2;
      enq_inst_2_i  = mk_inst(pc2);
      deq_pop_i     = pop;
      flush_i       = fl;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      idle();
      step();
      step();
      rst = 1'b0;

      chk("rst_count",  64'(count_o),       64'd0);
      chk("rst_v1",     64'(deq_valid_1_o), 64'd0);
      chk("rst_v2",     64'(deq_valid_2_o), 64'd0);
      chk("rst_pause",  64'(pause_o),       64'd0);
      chk("rst_pc1",    64'(deq_pc_1_o),    64'd0);
      chk("rst_inst2",  64'(deq_inst_2_o),  64'd0);

      // First pair into an empty buffer; nothing visible until the next cycle.
      drive(1'b1, 1'b1, 32'h0, 32'h4, 2'd0, 1'b0);
      #1;
      chk("nobypass_v1", 64'(deq_valid_1_o), 64'd0);
      step();
      chk("pair_v1",    64'(deq_valid_1_o), 64'd1);
      chk("pair_v2",    64'(deq_valid_2_o), 64'd1);
      chk("pair_pc1",   64'(deq_pc_1_o),    64'h0);
      chk("pair_pc2",   64'(deq_pc_2_o),    64'h4);
      chk("pair_inst1", 64'(deq_inst_1_o),  64'(mk_inst(32'h0)));
      chk("pair_inst2", 64'(deq_inst_2_o),  64'(mk_inst(32'h4)));
      chk("pair_count", 64'(count_o),       64'd2);

      // Fill to DEPTH with three more pairs.
      for (int i = 1; i < 4; i++) begin
         drive(1'b1, 1'b1, 32'(8 * i), 32'(8 * i + 4), 2'd0, 1'b0);
         step();
         chk("fill_count", 64'(count_o), 64'(2 * i + 2));
         chk("fill_pause", 64'(pause_o), (i == 3) ? 64'd1 : 64'd0);
      end

      // Fifth pair arrives while paused and must be dropped.
      drive(1'b1, 1'b1, 32'h20, 32'h24, 2'd0, 1'b0);
      step();
      chk("drop_count", 64'(count_o),    64'd8);
      chk("drop_pc1",   64'(deq_pc_1_o), 64'h0);

      idle();
      deq_pop_i = 2'd1;
      step();
      chk("pop1_count", 64'(count_o),    64'd7);
      chk("pop1_pause", 64'(pause_o),    64'd1);
      chk("pop1_pc1",   64'(deq_pc_1_o), 64'h4);
      chk("pop1_pc2",   64'(deq_pc_2_o), 64'h8);

      deq_pop_i = 2'd2;
      step();
      chk("pop2_count", 64'(count_o),    64'd5);
      chk("pop2_pause", 64'(pause_o),    64'd0);
      chk("pop2_pc1",   64'(deq_pc_1_o), 64'hC);

      // Flush with enqueue and pop in the same cycle.
      drive(1'b1, 1'b1, 32'h40, 32'h44, 2'd2, 1'b1);
      step();
      chk("flush_count", 64'(count_o),       64'd0);
      chk("flush_v1",    64'(deq_valid_1_o), 64'd0);
      chk("flush_v2",    64'(deq_valid_2_o), 64'd0);
      chk("flush_pc1",   64'(deq_pc_1_o),    64'd0);
      chk("flush_inst1", 64'(deq_inst_1_o),  64'd0);
      chk("flush_pause", 64'(pause_o),       64'd0);

      // Steady state across several pointer wraps.
      drive(1'b1, 1'b1, 32'h0, 32'h4, 2'd0, 1'b0);
      step();
      for (int k = 1; k <= 20; k++) begin
         drive(1'b1, 1'b1, 32'(8 * k), 32'(8 * k + 4), 2'd2, 1'b0);
         step();
         chk("ss_count", 64'(count_o),      64'd2);
         chk("ss_pc1",   64'(deq_pc_1_o),   64'(8 * k));
         chk("ss_pc2",   64'(deq_pc_2_o),   64'(8 * k + 4));
         chk("ss_inst2", 64'(deq_inst_2_o), 64'(mk_inst(32'(8 * k + 4))));
      end

      // Pop clamping; deq_pop = 3 acts as 2.
      idle();
      deq_pop_i = 2'd1;
      step();
      chk("clamp_c1",  64'(count_o),       64'd1);
      chk("clamp_pc1", 64'(deq_pc_1_o),    64'hA4);
      chk("clamp_v2",  64'(deq_valid_2_o), 64'd0);
      chk("clamp_pc2", 64'(deq_pc_2_o),    64'd0);
      deq_pop_i = 2'd3;
      step();
      chk("clamp_c0",  64'(count_o),       64'd0);
      chk("clamp_v1",  64'(deq_valid_1_o), 64'd0);

      // Slot 2 without slot 1 writes nothing.
      drive(1'b0, 1'b1, 32'h100, 32'h104, 2'd0, 1'b0);
      step();
      chk("v2only_c0", 64'(count_o), 64'd0);
      drive(1'b1, 1'b0, 32'h200, 32'h204, 2'd0, 1'b0);
      step();
      chk("single_c1", 64'(count_o), 64'd1);
      drive(1'b0, 1'b1, 32'h300, 32'h304, 2'd0, 1'b0);
      step();
      chk("v2only_c1",  64'(count_o),    64'd1);
      chk("v2only_pc1", 64'(deq_pc_1_o), 64'h200);
      idle();
      deq_pop_i = 2'd1;
      step();

      // Single-slot enqueue alternating with pop of one.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 32'(32'h400 + 4 * i), 32'h0, 2'd0, 1'b0);
         step();
         chk("alt_count", 64'(count_o),       64'd1);
         chk("alt_pc1",   64'(deq_pc_1_o),    64'(32'h400 + 4 * i));
         chk("alt_v2a",   64'(deq_valid_2_o), 64'd0);
         idle();
         deq_pop_i = 2'd1;
         step();
         chk("alt_empty", 64'(count_o),       64'd0);
         chk("alt_v2b",   64'(deq_valid_2_o), 64'd0);
      end

      // Reset mid-traffic dominates flush and enqueue.
      drive(1'b1, 1'b1, 32'h500, 32'h504, 2'd0, 1'b0);
      step();
      chk("pre_rst_count", 64'(count_o), 64'd2);
      drive(1'b1, 1'b1, 32'h508, 32'h50C, 2'd1, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle();
      chk("mid_rst_count", 64'(count_o),       64'd0);
      chk("mid_rst_v1",    64'(deq_valid_1_o), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
